// File: rtl/ss_pkg.sv
// Shared MIPS decode helpers for the superscalar front end.
// Holds opcode/funct constants plus small decode functions used by the
// pairing logic: destination register, branch/jump detection, memory
// access detection and "does this instruction read its rt field".
package ss_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BLEZ  = 6'h06;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FUNCT_JR   = 6'h08;
   localparam logic [5:0] FUNCT_JALR = 6'h09;

   localparam logic [4:0] REG_RA = 5'd31;

   // Architectural register written by the instruction; 0 means "none".
   function automatic logic [4:0] dest_reg(input logic [31:0] instr);
      logic [4:0] d;
      d = 5'd0;
      case (instr[31:26])
         OP_RTYPE: d = instr[15:11];
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: d = instr[20:16];
         OP_JAL:   d = REG_RA;
         default:  d = 5'd0;
      endcase
      return d;
   endfunction

   function automatic logic is_branch(input logic [31:0] instr);
      logic b;
      b = 1'b0;
      case (instr[31:26])
         OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: b = 1'b1;
         OP_RTYPE: b = (instr[5:0] == FUNCT_JR) || (instr[5:0] == FUNCT_JALR);
         default:  b = 1'b0;
      endcase
      return b;
   endfunction

   function automatic logic is_mem(input logic [31:0] instr);
      return (instr[31:26] == OP_LW) || (instr[31:26] == OP_SW);
   endfunction

   // rt is a source operand for R-type, stores and branches.
   function automatic logic reads_rt(input logic [31:0] instr);
      logic r;
      r = 1'b0;
      case (instr[31:26])
         OP_RTYPE, OP_SW, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/issue_queue_ss_pair_check.sv
// Combinational dual-issue legality check.
// Ports:
//   i_instr_a  - older instruction (slot 1)
//   i_instr_b  - younger instruction (slot 2 candidate)
//   o_pair_ok  - 1 when both may issue in the same cycle
module pair_check
   import ss_pkg::*;
(
   input  logic [31:0] i_instr_a,
   input  logic [31:0] i_instr_b,
   output logic        o_pair_ok
);

   logic [4:0] w_dest_a;
   logic [4:0] w_dest_b;
   logic [4:0] w_rs_b;
   logic [4:0] w_rt_b;
   logic       w_ctrl_a;
   logic       w_raw;
   logic       w_waw;
   logic       w_mem_conflict;

   assign w_dest_a = dest_reg(i_instr_a);
   assign w_dest_b = dest_reg(i_instr_b);
   assign w_rs_b   = i_instr_b[25:21];
   assign w_rt_b   = i_instr_b[20:16];
   assign w_ctrl_a = is_branch(i_instr_a);

   // $0 is never a real dependency, so a zero destination cannot conflict.
   assign w_raw = (w_dest_a != 5'd0) &&
                  ((w_rs_b == w_dest_a) ||
                   (reads_rt(i_instr_b) && (w_rt_b == w_dest_a)));
   assign w_waw = (w_dest_a != 5'd0) && (w_dest_a == w_dest_b);

   // Only one data-memory port downstream.
   assign w_mem_conflict = is_mem(i_instr_a) && is_mem(i_instr_b);

   assign o_pair_ok = !(w_ctrl_a || w_raw || w_waw || w_mem_conflict);

endmodule

// File: rtl/issue_queue_ss.sv
// Dual-issue instruction queue between fetch and superscalar decode.
// Buffers fetch pairs in program order and presents up to two
// instructions per cycle, holding slot 2 back when pairing is illegal.
// Ports:
//   clk, reset            - clock, async active-high reset
//   in_valid/in_ready     - fetch pair handshake (ready when >=2 free)
//   in_instr0/in_instr1   - older/younger instruction, in_pc is instr0's PC
//   stall                 - decode cannot accept this cycle
//   flush                 - branch redirect, empties the queue
//   instrD1/instrD2       - slot 1/2 instructions (0 when slot invalid)
//   pcD1/pcD2             - matching PCs (0 when slot invalid)
//   valid1/valid2         - slot issue valids
module issue_queue_ss
   import ss_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_instr0,
   input  logic [31:0] in_instr1,
   input  logic [31:0] in_pc,
   output logic        in_ready,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] instrD1,
   output logic [31:0] instrD2,
   output logic [31:0] pcD1,
   output logic [31:0] pcD2,
   output logic        valid1,
   output logic        valid2
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      r_instr [DEPTH];
   logic [31:0]      r_pc    [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic [PTR_W-1:0] w_rd_ptr1;
   logic [PTR_W-1:0] w_wr_ptr1;
   logic             w_push;
   logic             w_pair_ok;
   logic [1:0]       w_pop_n;
   logic [31:0]      w_head_instr;
   logic [31:0]      w_next_instr;

   assign w_rd_ptr1 = r_rd_ptr + PTR_W'(1);
   assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);

   // Ready looks only at the registered count; same-cycle pops are ignored
   // so there is no path from decode stall to fetch.
   assign in_ready = (r_count <= CNT_W'(DEPTH - 2));
   assign w_push   = in_valid && in_ready && !flush;

   assign w_head_instr = r_instr[r_rd_ptr];
   assign w_next_instr = r_instr[w_rd_ptr1];

   pair_check u_pair_check (
      .i_instr_a (w_head_instr),
      .i_instr_b (w_next_instr),
      .o_pair_ok (w_pair_ok)
   );

   assign valid1 = (r_count != CNT_W'(0));
   assign valid2 = (r_count >= CNT_W'(2)) && w_pair_ok;

   assign instrD1 = valid1 ? w_head_instr       : 32'h0;
   assign pcD1    = valid1 ? r_pc[r_rd_ptr]     : 32'h0;
   assign instrD2 = valid2 ? w_next_instr       : 32'h0;
   assign pcD2    = valid2 ? r_pc[w_rd_ptr1]    : 32'h0;

   assign w_pop_n = (stall || flush) ? 2'd0 : ({1'b0, valid1} + {1'b0, valid2});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(2);
         end
         r_count <= r_count + (w_push ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(w_pop_n);
      end
   end

   // Entry storage is deliberately not reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_instr[r_wr_ptr]  <= in_instr0;
         r_pc[r_wr_ptr]     <= in_pc;
         r_instr[w_wr_ptr1] <= in_instr1;
         r_pc[w_wr_ptr1]    <= in_pc + 32'd4;
      end
   end

endmodule

// File: tb/tb_issue_queue_ss.sv
module tb_issue_queue_ss;

   localparam int DEPTH = 8;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_instr0;
   logic [31:0] in_instr1;
   logic [31:0] in_pc;
   logic        in_ready;
   logic        stall;
   logic        flush;
   logic [31:0] instrD1;
   logic [31:0] instrD2;
   logic [31:0] pcD1;
   logic [31:0] pcD2;
   logic        valid1;
   logic        valid2;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: program-order list of queued entries.
   logic [31:0] mq_i[$];
   logic [31:0] mq_p[$];

   issue_queue_ss #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_instr0 (in_instr0),
      .in_instr1 (in_instr1),
      .in_pc     (in_pc),
      .in_ready  (in_ready),
      .stall     (stall),
      .flush     (flush),
      .instrD1   (instrD1),
      .instrD2   (instrD2),
      .pcD1      (pcD1),
      .pcD2      (pcD2),
      .valid1    (valid1),
      .valid2    (valid2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Instruction encoders
   function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction
   function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   // Model decode, written from the register-usage rules.
   function automatic int m_dest(logic [31:0] x);
      int op;
      op = int'(x[31:26]);
      if (op == 0) return int'(x[15:11]);
      if ((op >= 8 && op <= 15) || op == 35) return int'(x[20:16]);
      if (op == 3) return 31;
      return 0;
   endfunction

   function automatic bit m_pair_ok(logic [31:0] a, logic [31:0] b);
      int opa, opb, fna, da, db;
      bit [31:0] rmask;
      bit mema, memb;
      opa = int'(a[31:26]);
      opb = int'(b[31:26]);
      fna = int'(a[5:0]);
      da = m_dest(a);
      db = m_dest(b);
      if ((opa >= 2 && opa <= 7) || (opa == 0 && (fna == 8 || fna == 9))) return 0;
      rmask = 32'd1 << b[25:21];
      if (opb == 0 || opb == 43 || (opb >= 4 && opb <= 7)) rmask |= 32'd1 << b[20:16];
      if (da != 0 && rmask[da]) return 0;
      if (da != 0 && da == db) return 0;
      mema = (opa == 35 || opa == 43);
      memb = (opb == 35 || opb == 43);
      if (mema && memb) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] rand_instr();
      int k, a, b, c;
      k = $urandom_range(0, 9);
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      c = $urandom_range(0, 7);
      case (k)
         0, 1:    return enc_r(a, b, c, 32'h20);
         2:       return enc_r(a, b, c, 32'h22);
         3:       return enc_i(8, a, b, $urandom_range(0, 255));
         4:       return enc_i(35, a, b, 4);
         5:       return enc_i(43, a, b, 8);
         6:       return enc_i(4, a, b, 2);
         7:       return {6'h03, 26'($urandom)};
         8:       return enc_r(a, 0, 0, 8);
         default: return enc_i(15, 0, b, $urandom_range(0, 65535));
      endcase
   endfunction

   // Compare all outputs against the model; return entries that would pop
   // if decode accepts this cycle.
   task automatic check_outputs(output int n_issue);
      bit ev1, ev2;
      ev1 = (mq_i.size() >= 1);
      ev2 = (mq_i.size() >= 2) && m_pair_ok(mq_i[0], mq_i[1]);
      chk("valid1", 32'(valid1), 32'(ev1));
      chk("valid2", 32'(valid2), 32'(ev2));
      chk("instrD1", instrD1, ev1 ? mq_i[0] : 32'h0);
      chk("pcD1", pcD1, ev1 ? mq_p[0] : 32'h0);
      chk("instrD2", instrD2, ev2 ? mq_i[1] : 32'h0);
      chk("pcD2", pcD2, ev2 ? mq_p[1] : 32'h0);
      chk("in_ready", 32'(in_ready), 32'(mq_i.size() <= DEPTH - 2));
      n_issue = int'(ev1) + int'(ev2);
   endtask

   // One clock: entered and left just after a falling edge.
   task automatic cycle(input logic iv, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] pc, input logic st, input logic fl);
      int n_issue;
      bit rdy;
      check_outputs(n_issue);
      rdy = (mq_i.size() <= DEPTH - 2);
      in_valid  = iv;
      in_instr0 = i0;
      in_instr1 = i1;
      in_pc     = pc;
      stall     = st;
      flush     = fl;
      @(posedge clk);
      if (fl) begin
         mq_i.delete();
         mq_p.delete();
      end else begin
         if (!st) begin
            for (int k = 0; k < n_issue; k++) begin
               void'(mq_i.pop_front());
               void'(mq_p.pop_front());
            end
         end
         if (iv && rdy) begin
            mq_i.push_back(i0);
            mq_p.push_back(pc);
            mq_i.push_back(i1);
            mq_p.push_back(pc + 32'd4);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   logic [31:0] add_a, add_b, sub_c;
   logic [31:0] pc_run;
   int n_issue_tmp;

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_instr0 = '0; in_instr1 = '0; in_pc = '0;
      stall = 1'b0; flush = 1'b0;
      add_a = 32'h00221820;
      add_b = 32'h00853020;
      sub_c = 32'h00612022;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_outputs(n_issue_tmp);
      reset = 1'b0;
      @(negedge clk);

      // Independent pair
      cycle(1'b1, add_a, add_b, 32'h100, 1'b0, 1'b0);
      chk("indep_valid2", 32'(valid2), 32'd1);
      chk("indep_pcD2", pcD2, 32'h104);
      idle(1);
      chk("indep_empty", 32'(valid1), 32'd0);

      // RAW hold
      cycle(1'b1, add_a, sub_c, 32'h100, 1'b0, 1'b0);
      chk("raw_valid2", 32'(valid2), 32'd0);
      idle(1);
      chk("raw_pcD1", pcD1, 32'h104);
      chk("raw_instrD1", instrD1, sub_c);
      idle(1);

      // Branch in slot 1
      cycle(1'b1, enc_i(4, 1, 2, 16), add_b, 32'h200, 1'b0, 1'b0);
      chk("beq_valid2", 32'(valid2), 32'd0);
      idle(2);

      // lw followed by sw, no register overlap
      cycle(1'b1, enc_i(35, 1, 5, 0), enc_i(43, 2, 6, 4), 32'h300, 1'b0, 1'b0);
      chk("lwsw_valid2", 32'(valid2), 32'd0);
      idle(2);

      // Full and wrap
      pc_run = 32'h1000;
      for (int p = 0; p < 4; p++) begin
         cycle(1'b1, rand_instr(), rand_instr(), pc_run, 1'b1, 1'b0);
         pc_run += 8;
         chk("full_ready", 32'(in_ready), (p == 3) ? 32'd0 : 32'd1);
      end
      for (int p = 0; p < 40; p++) begin
         cycle(1'b1, rand_instr(), rand_instr(), pc_run, 1'b0, 1'b0);
         if (mq_p.size() != 0 && mq_p[mq_p.size()-1] == pc_run + 32'd4) pc_run += 8;
      end
      idle(DEPTH);

      // Flush with 6 entries held and a simultaneous push
      for (int p = 0; p < 3; p++) cycle(1'b1, rand_instr(), rand_instr(), 32'h400 + 32'(8*p), 1'b1, 1'b0);
      chk("flush_pre_ready", 32'(in_ready), 32'd1);
      cycle(1'b1, add_a, add_b, 32'h500, 1'b0, 1'b1);
      chk("flush_valid1", 32'(valid1), 32'd0);
      chk("flush_ready", 32'(in_ready), 32'd1);
      idle(1);
      chk("flush_absent", 32'(valid1), 32'd0);

      // Async reset mid-stream
      cycle(1'b1, add_a, add_b, 32'h600, 1'b1, 1'b0);
      chk("arst_pre_valid1", 32'(valid1), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid1", 32'(valid1), 32'd0);
      chk("arst_valid2", 32'(valid2), 32'd0);
      chk("arst_instrD1", instrD1, 32'h0);
      chk("arst_pcD1", pcD1, 32'h0);
      chk("arst_ready", 32'(in_ready), 32'd1);
      mq_i.delete();
      mq_p.delete();
      in_valid = 1'b1; in_instr0 = add_a; in_instr1 = add_b; in_pc = 32'h700;
      #1 reset = 1'b0;
      @(posedge clk);
      mq_i.push_back(add_a); mq_p.push_back(32'h700);
      mq_i.push_back(add_b); mq_p.push_back(32'h704);
      @(negedge clk);
      in_valid = 1'b0;
      chk("arst_first_push", pcD1, 32'h700);
      idle(2);

      // Randomized traffic
      pc_run = 32'h8000;
      for (int c = 0; c < 3000; c++) begin
         cycle(($urandom_range(0, 99) < 60), rand_instr(), rand_instr(), pc_run,
               ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 2));
         pc_run += 8;
      end
      idle(DEPTH);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/issue_queue_ss.md
# issue_queue_ss

Dual-issue instruction queue between fetch and the superscalar decode stage. Accepts fetch pairs (two 32-bit MIPS instructions plus PC), buffers them in program order, and each cycle presents up to two instructions on `instrD1`/`instrD2`, which feed the dual-port register-file read addresses directly. Pairing logic holds the second instruction back when it cannot legally issue alongside the first.

## Interface
- `DEPTH`, 8: queue entries; power of two and at least 4.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: fetch pair valid.
- `in_instr0` in 32: older instruction of the fetch pair.
- `in_instr1` in 32: younger instruction of the fetch pair.
- `in_pc` in 32: PC of `in_instr0`; `in_instr1` is at `in_pc+4`.
- `in_ready` out 1: queue can accept a pair; high when at least 2 entries are free.
- `stall` in 1: decode cannot accept; no pop this cycle.
- `flush` in 1: branch redirect; empties the queue.
- `instrD1`, `instrD2` out 32: slot 1 (oldest) and slot 2 instructions; `32'h0` when the slot is not valid.
- `pcD1`, `pcD2` out 32: matching PCs; 0 when the slot is not valid.
- `valid1`, `valid2` out 1: slot issue valid.

## Operation
- Circular buffer of `DEPTH` entries holding {instr, pc}. Read pointer, write pointer and count are `$clog2(DEPTH)`, `$clog2(DEPTH)` and `$clog2(DEPTH)+1` bits wide. Pointers wrap modulo `DEPTH`.
- **Push:** when `in_valid && in_ready && !flush`, write two entries, `in_instr0` first, and add 2 to count.
- **Slot 1 valid:** `valid1 = (count >= 1)`; slot 1 is the head entry.
- **Slot 2 valid:** `valid2 = (count >= 2) && pair_ok`; slot 2 is head+1.
- **`pair_ok` is false if any of the following holds:**
  - the head is a branch or jump (opcode 2–7 or R-type funct 8/9);
  - the second instruction reads the head's nonzero destination register (rs, or rt for R-type/store/branch);
  - both instructions have the same nonzero destination;
  - both instructions are loads or stores (single memory port).
- **Destination decode:**
  - R-type (op 0): rd.
  - addi/addiu/slti/sltiu/andi/ori/xori/lui/lw: rt.
  - jal: 31.
  - All others: none (treated as 0).
- **Pop:** when `!stall && !flush`, remove `valid1 + valid2` entries; the read pointer advances by 0, 1 or 2.
- **Simultaneous push and pop:** count changes by +2 − pops.
- **Flush:** takes priority over everything. On the next edge the read pointer, write pointer and count are 0, and a same-cycle push is dropped.
- **Reset:** pointers and count are 0; `in_ready=1`; `valid1=valid2=0`; `instrD*`, `pcD*` are 0. Entry storage is not reset.

## Timing
- Issue outputs are combinational from registered queue state; there is no combinational path from `in_*` to `instrD*`.
- A pair pushed at edge N can appear in the slots during cycle N+1. The minimum in-to-issue latency is 1 cycle.
- `in_ready` depends only on registered count. It is low when `count > DEPTH-2`, and it does not consider same-cycle pops.
- When `stall=1`, outputs stay stable and count can only grow.
- An asynchronous reset mid-operation clears state immediately. The first push is accepted on the first edge after `reset` deasserts.

## Structure
- Package `ss_pkg` holds:
  - opcode/funct constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_ADDI, …, FUNCT_JR, FUNCT_JALR);
  - function `dest_reg(instr)` returning 5 bits;
  - functions `is_branch(instr)` and `is_mem(instr)`.
- One sub-module, `pair_check`: purely combinational; computes `pair_ok` from two instructions, using `ss_pkg` functions. The FIFO lives in `issue_queue_ss`.

## Test plan
- **Independent pair:** reset, then push add $3,$1,$2 (`32'h00221820`) and add $6,$4,$5 (`32'h00853020`) at PC `0x100`. Next cycle: `valid1=valid2=1`, `pcD2=0x104`. After the pop, count is 0.
- **RAW hold:** push add $3,$1,$2 and sub $4,$3,$1. Cycle 1: `valid2=0`. Cycle 2: sub issues in slot 1 with `pcD1=0x104`.
- **Branch and memory pairing:**
  - beq in slot 1 always gives `valid2=0`.
  - lw followed by sw with no register overlap gives `valid2=0`.
- **Full and wrap:** with `stall=1`, push 4 pairs (`DEPTH=8`). `in_ready` drops to 0 after the 4th. Release `stall` and keep pushing through 3 pointer wraps; issue order matches push order exactly.
- **Flush:** with 6 entries held and `flush=1` plus a simultaneous push, next cycle count is 0, `valid1=0`, `in_ready=1`, and the pushed pair is absent.
- **Async reset mid-stream:** assert `reset` between edges while `valid1=1`. Outputs go to 0 immediately, before the next edge.
